pool2_window_reader: RTL and testbench
======================================

# pool2_window_reader

Pooling-2 engine: walks the 8×8 conv-2 output memory in non-overlapping 2×2 windows and takes the signed maximum of each window. It then issues one write per window into the 4×4 pooling-2 output memory, whose write-side counter is the next stage downstream. It sits between conv-2 output storage and P2 storage in the digit-recognition datapath. One `start` processes a full feature map.

## Interface
Parameters:
- `DATA_W`, 16: sample width, signed two's complement
- `IN_DIM`, 8: input map side; output side is `IN_DIM/2`

Ports:
- `clk`  in  1  single system clock
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `start`  in  1  begin one pass; sampled only in IDLE
- `rd_en`  out  1  read strobe to conv-2 memory
- `rd_addr`  out  6  conv-2 memory address, `row*IN_DIM+col`
- `rd_data`  in  DATA_W  conv-2 read data, valid the cycle after `rd_en`
- `wr_en`  out  1  one-cycle write strobe to P2 memory
- `wr_addr`  out  4  P2 address, `oy*4+ox`
- `wr_data`  out  DATA_W  window maximum
- `busy`  out  1  high while a pass is in progress
- `done`  out  1  sticky completion flag

## Operation
- States:
  - IDLE → RD on `start`.
  - RD: 4 cycles, sub-count k=0..3.
  - LAST: 1 cycle.
  - WR: 1 cycle.
  - After WR, go to RD for the next window, or to IDLE when the last window (w=15) completes.
- Window w=(oy,ox) is raster order, ox fastest. Read order in RD:
  - k0 = (2oy, 2ox)
  - k1 = (2oy, 2ox+1)
  - k2 = (2oy+1, 2ox)
  - k3 = (2oy+1, 2ox+1)
- `rd_en` is high for all 4 RD cycles and low otherwise. `rd_addr` is 0 when `rd_en` is low.
- Max register:
  - Loaded directly with the k0 sample; it is never compared against 0 or against a stale value.
  - Updated with the signed max of itself and each of the k1..k3 samples as they return.
  - The k3 sample arrives in LAST.
  - On equal values, the register keeps its current value.
- WR drives `wr_en`=1, `wr_addr`=w, and `wr_data`=max. `wr_addr` and `wr_data` are 0 outside WR.
- `done`:
  - Set on the cycle after the final WR.
  - Held until the next accepted `start` or reset.
  - An accepted `start` clears it in the same edge that enters RD.
- `start` while `busy` is ignored and has no effect on counters.
- Reset (any time, including mid-pass):
  - All outputs go to 0 and state goes to IDLE.
  - Window and k counters go to 0 and the max register goes to 0.
  - No partial write is issued.
- Window counter wraps 15→0 only through IDLE. No write ever targets addresses beyond 15.

## Timing
- `start` high at edge T (in IDLE): RD begins at cycle T+1.
- Window w occupies cycles T+1+6w … T+6+6w:
  - RD: T+1+6w..T+4+6w
  - LAST: T+5+6w
  - WR: T+6+6w
- 6 cycles per window; last WR at T+96.
- `busy` is high T+1..T+96.
- `done` rises at T+97. A new `start` is accepted from T+97.
- Memory contract: synchronous read with exactly 1-cycle latency, no backpressure.

## Configuration
- `POOL2_RELU_EN` defined: `wr_data` = max clamped to 0 if negative (ReLU fused after pooling).
- Not defined: the raw signed max is written unchanged.
- Timing is identical in both builds.

## Structure
- Shared package `pool_pkg`:
  - `DATA_W`
  - `C2_DIM`=8 and `P2_DIM`=4
  - address-width constants
  - the state enum `pool_state_t` (IDLE, RD, LAST, WR)
- Sub-module `signed_max2`: combinational signed maximum of two `DATA_W` operands. It is instantiated once in the max-register update path.

## Test plan
- Ramp map `rd_data = addr`:
  - 16 writes, `wr_data` = 9, 11, 13, 15, 25, … , 63 at `wr_addr` 0..15.
  - First `wr_en` at T+6; `done` at T+97.
- All-negative map (-100-addr), RELU off:
  - Writes equal the per-window k0 value, e.g. addr0 → -100.
  - The first sample is loaded, not compared with 0.
- Same negative map with `POOL2_RELU_EN` defined: all 16 `wr_data` = 0.
- Mixed window {5, 0x7FFF, -32768, 7} at window 0: `wr_data`=0x7FFF. This checks signed rather than unsigned compare.
- Reset low at T+40 (mid window 6):
  - All outputs are 0 next cycle.
  - No further `wr_en`.
  - A restart produces a full 16-write pass.
- `start` pulsed at T+10 and T+50 while busy: ignored, exactly 16 writes. A `start` at T+97 clears `done` and starts a new pass.

Source files
------------

// File: rtl/pool2_window_reader_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
//   Shared constants and types for the pooling-2 window reader.
//   - DATA_W        : sample width (signed two's complement)
//   - C2_DIM/P2_DIM : conv-2 input side and pooling-2 output side
//   - C2_AW/P2_AW   : address widths of the conv-2 and P2 memories
//   - pool_state_t  : engine states IDLE -> RD -> LAST -> WR
//   - relu_clamp()  : clamps a negative sample to zero, used when the build
//                     defines POOL2_RELU_EN
// -----------------------------------------------------------------------------
package pool_pkg;

  localparam int DATA_W = 16;
  localparam int C2_DIM = 8;
  localparam int P2_DIM = C2_DIM / 2;
  localparam int N_WIN  = P2_DIM * P2_DIM;
  localparam int C2_AW  = $clog2(C2_DIM * C2_DIM);
  localparam int P2_AW  = $clog2(N_WIN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for start
    RD   = 2'd1,  // four reads of the current 2x2 window
    LAST = 2'd2,  // k3 sample returns from memory
    WR   = 2'd3   // window maximum written to P2 memory
  } pool_state_t;

  function automatic logic signed [DATA_W-1:0] relu_clamp(
    input logic signed [DATA_W-1:0] v
  );
    return v[DATA_W-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/pool2_window_reader_if.sv
// -----------------------------------------------------------------------------
// pool2_window_reader_if
//   Bundles the control handshake and both memory buses of the pooling-2
//   engine.
//   - start, busy, done          : pass control and status
//   - rd_en, rd_addr, rd_data    : conv-2 memory read port (1-cycle latency)
//   - wr_en, wr_addr, wr_data    : P2 memory write port
//   Modports:
//   - master : the engine
//   - slave  : the surrounding datapath / memories
// -----------------------------------------------------------------------------
interface pool2_window_reader_if #(
  parameter int DATA_W = pool_pkg::DATA_W
);
  import pool_pkg::*;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     rd_en;
  logic [C2_AW-1:0]         rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [P2_AW-1:0]         wr_addr;
  logic signed [DATA_W-1:0] wr_data;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/pool2_window_reader_max.sv
// -----------------------------------------------------------------------------
// signed_max2
//   Combinational signed maximum of two operands. On a tie the a_i operand is
//   returned, so a running maximum fed back on a_i keeps its current value.
//   Ports:
//   - a_i   : current maximum
//   - b_i   : new sample
//   - max_o : signed max(a_i, b_i)
// -----------------------------------------------------------------------------
module signed_max2 #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] max_o
);

  // Both operands are declared signed, so this is a two's-complement compare.
  assign max_o = (b_i > a_i) ? b_i : a_i;

endmodule

// File: rtl/pool2_window_reader.sv
// -----------------------------------------------------------------------------
// pool2_window_reader
//   Pooling-2 engine. One start walks the IN_DIM x IN_DIM conv-2 map in
//   non-overlapping 2x2 windows (raster order, ox fastest), takes the signed
//   maximum of each window and writes it to the (IN_DIM/2)^2 P2 memory.
//   Each window takes 6 cycles: RD x4, LAST, WR.
//   Ports:
//   - clk   : system clock
//   - reset : asynchronous, active-low reset
//   - bus   : control + conv-2 read + P2 write signals (master side)
//   Build option:
//   - POOL2_RELU_EN : written value is the window maximum clamped at zero;
//                     otherwise the raw signed maximum. Timing is identical.
// -----------------------------------------------------------------------------
module pool2_window_reader #(
  parameter int DATA_W = pool_pkg::DATA_W,
  parameter int IN_DIM = pool_pkg::C2_DIM
) (
  input  logic                   clk,
  input  logic                   reset,
  pool2_window_reader_if.master  bus
);
  import pool_pkg::*;

  localparam int unsigned        IN_DIM_U  = IN_DIM;
  localparam int unsigned        OUT_DIM_U = IN_DIM / 2;
  localparam logic [P2_AW-1:0]   LAST_WIN  = P2_AW'(OUT_DIM_U * OUT_DIM_U - 1);

  pool_state_t              state_q, state_d;
  logic [1:0]               k_q, k_d;
  logic [P2_AW-1:0]         win_q, win_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic                     done_q, done_d;

  logic signed [DATA_W-1:0] max_cmp;
  logic signed [DATA_W-1:0] wr_val;
  logic [C2_AW-1:0]         rd_addr_c;
  logic                     sample_first;
  logic                     sample_more;
  int unsigned              oy_u, ox_u, row_u, col_u;

  // ---------------------------------------------------------------------------
  // Read-data bookkeeping. rd_data carries the sample requested one cycle
  // earlier: k0 returns in RD k=1, k1 in k=2, k2 in k=3 and k3 in LAST.
  // ---------------------------------------------------------------------------
  assign sample_first = (state_q == RD) && (k_q == 2'd1);
  assign sample_more  = ((state_q == RD) && (k_q > 2'd1)) || (state_q == LAST);

  signed_max2 #(.DATA_W(DATA_W)) u_max (
    .a_i   (max_q),
    .b_i   (bus.rd_data),
    .max_o (max_cmp)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    k_d     = k_q;
    win_d   = win_q;
    max_d   = max_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        // start is only looked at here, so a start while busy is ignored.
        if (bus.start) begin
          state_d = RD;
          k_d     = 2'd0;
          win_d   = '0;
          done_d  = 1'b0;
        end
      end
      RD: begin
        k_d = k_q + 2'd1;  // wraps 3 -> 0, ready for the next window
        if (k_q == 2'd3) state_d = LAST;
      end
      LAST: state_d = WR;
      WR: begin
        win_d = win_q + 1'b1;  // last window wraps to 0 while returning to IDLE
        if (win_q == LAST_WIN) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase

    // k0 is loaded outright so the window max never sees zero or a stale value.
    if (sample_first)     max_d = bus.rd_data;
    else if (sample_more) max_d = max_cmp;
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of block evaluation order.
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      win_q   <= '0;
      max_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      win_q   <= win_d;
      max_q   <= max_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read address: window (oy,ox) reads (2oy,2ox), (2oy,2ox+1), (2oy+1,2ox),
  // (2oy+1,2ox+1) for k = 0..3, i.e. k[1] selects the row, k[0] the column.
  // ---------------------------------------------------------------------------
  always_comb begin
    oy_u      = 32'(win_q) / OUT_DIM_U;
    ox_u      = 32'(win_q) % OUT_DIM_U;
    row_u     = 2 * oy_u + 32'(k_q[1]);
    col_u     = 2 * ox_u + 32'(k_q[0]);
    rd_addr_c = C2_AW'(row_u * IN_DIM_U + col_u);
  end

`ifdef POOL2_RELU_EN
  assign wr_val = relu_clamp(max_q);
`else
  assign wr_val = max_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs are decoded from registered state; address and data buses are
  // forced to zero whenever their strobe is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.rd_en   = (state_q == RD);
    bus.rd_addr = bus.rd_en ? rd_addr_c : '0;
    bus.wr_en   = (state_q == WR);
    bus.wr_addr = bus.wr_en ? win_q : '0;
    bus.wr_data = bus.wr_en ? wr_val : '0;
    bus.busy    = (state_q != IDLE);
    bus.done    = done_q;
  end

endmodule

// File: tb/tb_pool2_window_reader.sv
// -----------------------------------------------------------------------------
// tb_pool2_window_reader
//   Directed bench for pool2_window_reader: ramp map, all-negative map,
//   signed-compare corner window, mid-pass reset, start while busy and
//   back-to-back restart. Expected write tables are written out by hand.
//   Compiling with POOL2_RELU_EN selects the clamped expectations.
// -----------------------------------------------------------------------------
module tb_pool2_window_reader;
  import pool_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pool2_window_reader_if #(.DATA_W(16)) bus ();

  pool2_window_reader #(.DATA_W(16), .IN_DIM(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // conv-2 memory model: synchronous read, exactly one cycle of latency
  logic signed [15:0] mem [64];
  always @(posedge clk or negedge reset) begin
    if (!reset) bus.rd_data <= '0;
    else        bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : '0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t_start = 0;
  int n_total = 0;
  int n_pass  = 0;
  int wr_addr_q [$];
  int wr_data_q [$];
  int wr_rel_q  [$];

  // P2 write monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_addr_q.push_back(int'(bus.wr_addr));
      wr_data_q.push_back(int'(bus.wr_data));
      wr_rel_q.push_back(cyc - t_start + 1);
    end
  end

  function automatic int rel();
    return cyc - t_start + 1;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},   32'(bus.rd_en),   0);
    check({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
    check({tag, "_wr_en"},   32'(bus.wr_en),   0);
    check({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    check({tag, "_wr_data"}, 32'(bus.wr_data), 0);
    check({tag, "_busy"},    32'(bus.busy),    0);
    check({tag, "_done"},    32'(bus.done),    0);
  endtask

  // Called at a negedge: start is sampled at the next posedge (edge T).
  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t_start   = cyc;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_rel_q.delete();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"},     32'(bus.done), 1);
    check({tag, "_done_rel"}, rel(),         97);
  endtask

  task automatic check_writes(input string tag, input int exp [16]);
    check({tag, "_nwr"}, wr_addr_q.size(), 16);
    for (int i = 0; i < wr_addr_q.size() && i < 16; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp[i]);
      check($sformatf("%s_rel%0d",  tag, i), wr_rel_q[i],  6 + 6 * i);
    end
  endtask

  int ramp_exp  [16] = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};
  int neg_raw   [16] = '{-100, -102, -104, -106, -116, -118, -120, -122,
                         -132, -134, -136, -138, -148, -150, -152, -154};
  int k_addr    [4]  = '{0, 1, 8, 9};
  int neg_exp   [16];
  int mixed_exp [16];

  initial begin
    bus.start = 1'b0;
`ifdef POOL2_RELU_EN
    foreach (neg_exp[i]) neg_exp[i] = 0;
`else
    neg_exp = neg_raw;
`endif
    foreach (mixed_exp[i]) mixed_exp[i] = 0;
    mixed_exp[0] = 32767;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // ---- ramp map rd_data = addr ----
    for (int a = 0; a < 64; a++) mem[a] = 16'(a);
    do_start();
    check("ramp_busy_t1", 32'(bus.busy), 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ramp_rd_en_k%0d", k),   32'(bus.rd_en),   1);
      check($sformatf("ramp_rd_addr_k%0d", k), 32'(bus.rd_addr), k_addr[k]);
      @(negedge clk);
    end
    check("ramp_rd_en_last",   32'(bus.rd_en),   0);
    check("ramp_rd_addr_last", 32'(bus.rd_addr), 0);
    check("ramp_wr_en_last",   32'(bus.wr_en),   0);
    wait_done("ramp");
    check("ramp_busy_done", 32'(bus.busy), 0);
    check_writes("ramp", ramp_exp);
    repeat (5) @(negedge clk);
    check("ramp_done_held", 32'(bus.done), 1);

    // ---- all-negative map: first sample loaded, never compared with 0 ----
    for (int a = 0; a < 64; a++) mem[a] = 16'(-100 - a);
    do_start();
    check("neg_done_clr", 32'(bus.done), 0);
    wait_done("neg");
    check_writes("neg", neg_exp);

    // ---- signed compare corner in window 0 ----
    for (int a = 0; a < 64; a++) mem[a] = '0;
    mem[0] = 16'sd5;
    mem[1] = 16'sh7FFF;
    mem[8] = 16'sh8000;
    mem[9] = 16'sd7;
    do_start();
    wait_done("mixed");
    check_writes("mixed", mixed_exp);

    // ---- reset in the middle of window 6 ----
    for (int a = 0; a < 64; a++) mem[a] = 16'(a);
    do_start();
    while (rel() < 40) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrst");
    check("midrst_nwr", wr_addr_q.size(), 6);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_nwr_after", wr_addr_q.size(), 6);
    check("midrst_idle_busy", 32'(bus.busy), 0);
    do_start();
    wait_done("restart");
    check_writes("restart", ramp_exp);

    // ---- start pulses while busy are ignored ----
    @(negedge clk);
    do_start();
    while (rel() < 10) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (rel() < 50) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busystart");
    check_writes("busystart", ramp_exp);

    // ---- start at T+97 clears done and runs a fresh pass ----
    do_start();
    check("b2b_done_clr", 32'(bus.done), 0);
    check("b2b_busy",     32'(bus.busy), 1);
    wait_done("b2b");
    check_writes("b2b", ramp_exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
